reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 8, meaning register and data-port width in bits; it SHALL equal the ALU operand width.
REQ-002 Parameter NUM_REGS, default 8, meaning number of architectural registers (power of two).
REQ-003 Parameter ADDR_W, default 3, meaning register address width; it SHALL equal log2(NUM_REGS).
REQ-004 Port CLK  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 Port RESET  input  1  asynchronous, active-high reset.
REQ-006 Port IN  input  DATA_W  write data (ALU RESULT or immediate from the datapath).
REQ-007 Port INADDRESS  input  ADDR_W  write register index.
REQ-008 Port WRITE  input  1  write enable.
REQ-009 Port OUT1ADDRESS  input  ADDR_W  read port 1 index.
REQ-010 Port OUT2ADDRESS  input  ADDR_W  read port 2 index.
REQ-011 Port REGOUT1  output  DATA_W  read port 1 data; drives ALU DATA1.
REQ-012 Port REGOUT2  output  DATA_W  read port 2 data; drives the operand path to ALU DATA2.
REQ-013 Port WRITE_DONE  output  1  one-cycle pulse confirming a committed write.
REQ-014 Port WRITE_COUNT  output  8  number of committed writes since reset.

Function
REQ-015 Storage SHALL be NUM_REGS registers of DATA_W bits; no register is hardwired, so register 0 is writable.
REQ-016 On a rising CLK edge with WRITE=1 and RESET=0, register[INADDRESS] SHALL take IN.
REQ-017 With WRITE=0 at the edge, no register SHALL change.
REQ-018 Reads SHALL be combinational: REGOUT1 = register[OUT1ADDRESS] and REGOUT2 = register[OUT2ADDRESS]; outputs change within the same cycle as the address or the stored value changes.
REQ-019 Read-during-write to the same index SHALL return the old value until the write edge and the new value after it; there is no write-through bypass.
REQ-020 Both read ports MAY address the same register simultaneously, and both SHALL return the identical value.
REQ-021 WRITE_DONE SHALL be a registered output, 1 for exactly the cycle following each edge at which a write commits, and 0 otherwise.
REQ-022 WRITE_COUNT SHALL increment by 1 per committed write, modulo 256 (255 -> 0 wrap, no saturation).
REQ-023 Back-to-back writes on consecutive edges SHALL each commit; WRITE_DONE stays high across them and WRITE_COUNT increments each cycle.
REQ-024 X or Z on INADDRESS while WRITE=1 is a usage error; the bench SHALL flag it with an assertion.

Reset
REQ-025 RESET=1 SHALL asynchronously clear every register, WRITE_DONE and WRITE_COUNT to 0, with no dependence on CLK.
REQ-026 While RESET=1, writes SHALL be ignored, and REGOUT1/REGOUT2 SHALL read 0 for any address.
REQ-027 Reset asserted mid-cycle after a write edge SHALL discard the just-written value and clear WRITE_DONE immediately.
REQ-028 After RESET deasserts, the first rising edge with WRITE=1 SHALL commit normally.

Structure
REQ-029 DATA_W, NUM_REGS and ADDR_W defaults SHALL live in the shared CPU package, next to the ALU SELECT opcode constants.
REQ-030 The block SHALL be a single module with no sub-module; storage is an array with a per-index write decode.

Verification
REQ-031 Scenario, reset check: assert RESET, sweep all 8 addresses on both read ports -> REGOUT1 = REGOUT2 = 0x00 and WRITE_COUNT = 0.
REQ-032 Scenario, basic write and dual read: write 0x5A to r3, then set OUT1ADDRESS = 3 and OUT2ADDRESS = 3 -> both ports read 0x5A; WRITE_DONE is high for 1 cycle; WRITE_COUNT = 1.
REQ-033 Scenario, read-during-write: r2 = 0x11, write 0x22 to r2 with OUT1ADDRESS = 2 -> REGOUT1 = 0x11 before the edge and 0x22 after it.
REQ-034 Scenario, write disabled: WRITE = 0, IN = 0xFF, INADDRESS = 5 for 4 edges -> r5 unchanged, WRITE_DONE = 0, WRITE_COUNT unchanged.
REQ-035 Scenario, counter wrap: 256 consecutive writes from reset -> WRITE_COUNT returns to 0x00, and WRITE_DONE stays high throughout.
REQ-036 Scenario, asynchronous reset mid-operation: write 0x7E to r7, then assert RESET between clock edges -> REGOUT for r7 = 0x00 and WRITE_DONE = 0 before the next edge.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared CPU package: datapath widths, register-file sizing and ALU SELECT
// opcodes, kept together so the ALU and register file always agree on widths.
package reg_file_pkg;

  // Datapath / register-file sizing shared by the ALU and the register file.
  localparam int CPU_DATA_W   = 8;
  localparam int CPU_NUM_REGS = 8;
  localparam int CPU_ADDR_W   = 3;

  // Width of the committed-write counter exposed by the register file.
  localparam int WRITE_COUNT_W = 8;

  // ALU SELECT opcodes driven by the control unit.
  typedef enum logic [2:0] {
    ALU_SEL_FWD = 3'b000,
    ALU_SEL_ADD = 3'b001,
    ALU_SEL_AND = 3'b010,
    ALU_SEL_OR  = 3'b011
  } alu_sel_e;

  // Modulo-256 increment; the counter wraps 255 -> 0 rather than saturating.
  function automatic logic [WRITE_COUNT_W-1:0] count_inc(
    input logic [WRITE_COUNT_W-1:0] value
  );
    return value + 8'd1;
  endfunction

endpackage : reg_file_pkg

// File: rtl/reg_file_if.sv
// Register-file bus: one write port, two combinational read ports and the
// write-commit status. The datapath is the master, the register file the slave.
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W
);

  logic [DATA_W-1:0]        IN;
  logic [ADDR_W-1:0]        INADDRESS;
  logic                     WRITE;
  logic [ADDR_W-1:0]        OUT1ADDRESS;
  logic [ADDR_W-1:0]        OUT2ADDRESS;
  logic [DATA_W-1:0]        REGOUT1;
  logic [DATA_W-1:0]        REGOUT2;
  logic                     WRITE_DONE;
  logic [WRITE_COUNT_W-1:0] WRITE_COUNT;

  modport master (
    output IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS,
    input  REGOUT1, REGOUT2, WRITE_DONE, WRITE_COUNT
  );

  modport slave (
    input  IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS,
    output REGOUT1, REGOUT2, WRITE_DONE, WRITE_COUNT
  );

endinterface : reg_file_if

// File: rtl/reg_file.sv
// CPU register file: NUM_REGS x DATA_W storage with one synchronous write port
// and two combinational read ports. Register 0 is an ordinary writable register.
// Reads return the stored value only (no write-through), so a read of the
// register being written shows the old value until the write edge.
// A registered WRITE_DONE pulse and a wrapping 8-bit counter report commits.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = CPU_DATA_W,
  parameter int NUM_REGS = CPU_NUM_REGS,
  parameter int ADDR_W   = CPU_ADDR_W
) (
  input  logic       CLK,
  input  logic       RESET,
  reg_file_if.slave  bus
);

  // Architectural register storage and its next state.
  logic [DATA_W-1:0]        regs_q [NUM_REGS];
  logic [DATA_W-1:0]        regs_d [NUM_REGS];

  // Commit status.
  logic                     write_done_q;
  logic                     write_done_d;
  logic [WRITE_COUNT_W-1:0] write_count_q;
  logic [WRITE_COUNT_W-1:0] write_count_d;

  // Per-index write decode: only the addressed register loads IN when WRITE=1.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (bus.WRITE && (bus.INADDRESS == ADDR_W'(i))) begin
        regs_d[i] = bus.IN;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Commit status next state: pulse and count on every enabled edge.
  always_comb begin
    write_done_d  = 1'b0;
    write_count_d = write_count_q;
    if (bus.WRITE) begin
      write_done_d  = 1'b1;
      write_count_d = count_inc(write_count_q);
    end else begin
      write_done_d  = 1'b0;
      write_count_d = write_count_q;
    end
  end

  // Storage update; RESET clears every register immediately, independent of CLK.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Commit pulse and counter; both drop to zero the moment RESET rises.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      write_done_q  <= 1'b0;
      write_count_q <= 8'd0;
    end else begin
      write_done_q  <= write_done_d;
      write_count_q <= write_count_d;
    end
  end

  // Combinational read ports straight off the storage array; during RESET the
  // array is already cleared, so every address reads zero.
  assign bus.REGOUT1     = regs_q[bus.OUT1ADDRESS];
  assign bus.REGOUT2     = regs_q[bus.OUT2ADDRESS];
  assign bus.WRITE_DONE  = write_done_q;
  assign bus.WRITE_COUNT = write_count_q;

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: table-driven vectors with a scoreboard of
// post-edge expectations, plus hand-written reset, wrap and async-reset sequences.
module tb_reg_file;
  import reg_file_pkg::*;

  logic CLK;
  logic RESET;

  reg_file_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  reg_file #(.DATA_W(8), .NUM_REGS(8), .ADDR_W(3)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Usage check: an unknown write index while writing is an error.
  always @(posedge CLK) begin
    if (!RESET && bus.WRITE === 1'b1) begin
      assert (!$isunknown(bus.INADDRESS))
      else $error("FAIL x_inaddress: INADDRESS=%b while WRITE=1", bus.INADDRESS);
    end
  end

  typedef struct {
    logic       we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [2:0] a1;
    logic [2:0] a2;
    logic [7:0] pre1;   // REGOUT1 before the edge
    logic [7:0] post1;  // REGOUT1 after the edge
    logic [7:0] post2;  // REGOUT2 after the edge
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] r1;
    logic [7:0] r2;
    logic       done;
    logic [7:0] count;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] model_count;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    bus.WRITE = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    model_count = 8'd0;
  endtask

  // Apply one table vector: check the pre-edge read, queue the post-edge
  // expectation, then pop and compare after the edge.
  task automatic apply_vec(input int idx, input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge CLK);
    bus.WRITE       = v.we;
    bus.INADDRESS   = v.waddr;
    bus.IN          = v.wdata;
    bus.OUT1ADDRESS = v.a1;
    bus.OUT2ADDRESS = v.a2;
    #1;
    check($sformatf("vec%0d_pre_regout1", idx), bus.REGOUT1, v.pre1);
    if (v.we) model_count = model_count + 8'd1;
    e.idx = idx; e.r1 = v.post1; e.r2 = v.post2; e.done = v.we; e.count = model_count;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    if (sb_q.size() == 0) begin
      check($sformatf("vec%0d_scoreboard_empty", idx), 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      check($sformatf("vec%0d_regout1", got.idx), bus.REGOUT1, got.r1);
      check($sformatf("vec%0d_regout2", got.idx), bus.REGOUT2, got.r2);
      check($sformatf("vec%0d_write_done", got.idx), bus.WRITE_DONE, got.done);
      check($sformatf("vec%0d_write_count", got.idx), bus.WRITE_COUNT, got.count);
    end
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    // we waddr wdata a1 a2 pre1 post1 post2
    vecs[0] = '{1'b1, 3'd3, 8'h5A, 3'd3, 3'd3, 8'h00, 8'h5A, 8'h5A}; // basic write, dual read
    vecs[1] = '{1'b1, 3'd2, 8'h11, 3'd2, 3'd3, 8'h00, 8'h11, 8'h5A}; // back-to-back
    vecs[2] = '{1'b1, 3'd2, 8'h22, 3'd2, 3'd2, 8'h11, 8'h22, 8'h22}; // read-during-write
    vecs[3] = '{1'b0, 3'd5, 8'hFF, 3'd5, 3'd3, 8'h00, 8'h00, 8'h5A}; // write disabled x4
    vecs[4] = '{1'b0, 3'd5, 8'hFF, 3'd5, 3'd3, 8'h00, 8'h00, 8'h5A};
    vecs[5] = '{1'b0, 3'd5, 8'hFF, 3'd5, 3'd3, 8'h00, 8'h00, 8'h5A};
    vecs[6] = '{1'b0, 3'd5, 8'hFF, 3'd5, 3'd3, 8'h00, 8'h00, 8'h5A};
    vecs[7] = '{1'b1, 3'd0, 8'hA5, 3'd0, 3'd2, 8'h00, 8'hA5, 8'h22}; // r0 writable
    vecs[8] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd7, 8'hA5, 8'hA5, 8'h00};
    vecs[9] = '{1'b1, 3'd7, 8'hC3, 3'd7, 3'd0, 8'h00, 8'hC3, 8'hA5};

    RESET = 1'b1;
    bus.WRITE = 1'b0; bus.IN = 8'h00; bus.INADDRESS = 3'd0;
    bus.OUT1ADDRESS = 3'd0; bus.OUT2ADDRESS = 3'd0;
    model_count = 8'd0;

    // Reset check: writes attempted during reset are ignored; all addresses read 0.
    @(negedge CLK);
    bus.WRITE = 1'b1; bus.IN = 8'hEE; bus.INADDRESS = 3'd4;
    @(posedge CLK); #1;
    for (int a = 0; a < 8; a++) begin
      bus.OUT1ADDRESS = 3'(a);
      bus.OUT2ADDRESS = 3'(7 - a);
      #1;
      check($sformatf("reset_regout1_a%0d", a), bus.REGOUT1, 8'h00);
      check($sformatf("reset_regout2_a%0d", 7 - a), bus.REGOUT2, 8'h00);
    end
    check("reset_write_count", bus.WRITE_COUNT, 8'd0);
    check("reset_write_done", bus.WRITE_DONE, 1'b0);
    @(negedge CLK);
    bus.WRITE = 1'b0;
    RESET = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      apply_vec(i, vecs[i]);
    end

    // Counter wrap: 256 back-to-back writes from reset.
    do_reset();
    bus.OUT1ADDRESS = 3'd5;
    for (int i = 0; i < 256; i++) begin
      @(negedge CLK);
      bus.WRITE = 1'b1; bus.INADDRESS = 3'(i); bus.IN = 8'(i);
      @(posedge CLK); #1;
      model_count = model_count + 8'd1;
      check($sformatf("wrap_done_%0d", i), bus.WRITE_DONE, 1'b1);
      check($sformatf("wrap_count_%0d", i), bus.WRITE_COUNT, model_count);
    end
    check("wrap_count_final", bus.WRITE_COUNT, 8'h00);
    check("wrap_r5_last", bus.REGOUT1, 8'hFD);
    @(negedge CLK);
    bus.WRITE = 1'b0;
    @(posedge CLK); #1;
    check("wrap_idle_done", bus.WRITE_DONE, 1'b0);
    check("wrap_idle_count", bus.WRITE_COUNT, 8'h00);

    // Async reset mid-cycle right after a write edge.
    @(negedge CLK);
    bus.WRITE = 1'b1; bus.INADDRESS = 3'd7; bus.IN = 8'h7E;
    bus.OUT1ADDRESS = 3'd7; bus.OUT2ADDRESS = 3'd7;
    @(posedge CLK); #1;
    check("async_pre_r7", bus.REGOUT1, 8'h7E);
    check("async_pre_done", bus.WRITE_DONE, 1'b1);
    #1;
    RESET = 1'b1;
    #1;
    check("async_r7_port1", bus.REGOUT1, 8'h00);
    check("async_r7_port2", bus.REGOUT2, 8'h00);
    check("async_done", bus.WRITE_DONE, 1'b0);
    check("async_count", bus.WRITE_COUNT, 8'h00);

    // First write after reset release commits normally.
    @(negedge CLK);
    RESET = 1'b0;
    bus.WRITE = 1'b1; bus.INADDRESS = 3'd1; bus.IN = 8'h3C;
    bus.OUT1ADDRESS = 3'd1; bus.OUT2ADDRESS = 3'd7;
    @(posedge CLK); #1;
    check("post_reset_r1", bus.REGOUT1, 8'h3C);
    check("post_reset_r7", bus.REGOUT2, 8'h00);
    check("post_reset_done", bus.WRITE_DONE, 1'b1);
    check("post_reset_count", bus.WRITE_COUNT, 8'd1);
    @(negedge CLK);
    bus.WRITE = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_reg_file
